// File: rtl/stc_carrier_nco.sv
// Carrier NCO: loop lag + lead + sweep offset integrated into a 32-bit phase accumulator, 12-bit phase out.
// Optional phase dither via a 16-bit LFSR when STC_NCO_DITHER_EN is defined.
module stc_carrier_nco (
  input  logic               clk,
  input  logic               reset,
  input  logic               carrierFreqEn,
  input  logic signed [31:0] carrierFreqOffset,
  input  logic signed [31:0] carrierLeadFreq,
  input  logic               freqAcquired,
  input  logic               sweepEnable,
  input  logic [15:0]        sweepStep,
  input  logic [30:0]        sweepLimit,
  output logic [11:0]        ncoPhase,
  output logic               ncoPhaseEn,
  output logic signed [31:0] sweepOffset,
  output logic               sweepActive
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_t;

  sweep_state_t       state_r;
  sweep_state_t       state_s;
  logic signed [31:0] offset_s;
  logic signed [32:0] up_sum_s;
  logic signed [32:0] down_sum_s;
  logic signed [32:0] pos_limit_s;
  logic signed [32:0] neg_limit_s;

  logic [31:0] sum_r;
  logic        valid1_r;
  logic [31:0] phase_acc_r;
  logic        valid2_r;
  logic [11:0] phase_word_s;

  // Sweep next-state and next-offset; 33-bit intermediates keep the bound compares overflow-free.
  always_comb begin
    state_s     = state_r;
    offset_s    = sweepOffset;
    pos_limit_s = {2'b00, sweepLimit};
    neg_limit_s = 33'sd0 - pos_limit_s;
    up_sum_s    = {sweepOffset[31], sweepOffset} + {17'd0, sweepStep};
    down_sum_s  = {sweepOffset[31], sweepOffset} - {17'd0, sweepStep};
    if (!carrierFreqEn) begin
      state_s  = state_r;
    end else if (!sweepEnable) begin
      state_s  = IDLE;
      offset_s = 32'sd0;
    end else if (freqAcquired) begin
      state_s  = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = UP;
        end
        UP: begin
          if (up_sum_s >= pos_limit_s) begin
            offset_s = pos_limit_s[31:0];
            state_s  = DOWN;
          end else begin
            offset_s = up_sum_s[31:0];
          end
        end
        DOWN: begin
          if (down_sum_s <= neg_limit_s) begin
            offset_s = neg_limit_s[31:0];
            state_s  = UP;
          end else begin
            offset_s = down_sum_s[31:0];
          end
        end
        default: begin
          state_s  = IDLE;
          offset_s = sweepOffset;
        end
      endcase
    end
  end

  // Sweep state, offset and activity flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      sweepOffset <= 32'sd0;
      sweepActive <= 1'b0;
    end else begin
      state_r     <= state_s;
      sweepOffset <= offset_s;
      sweepActive <= (state_s != IDLE);
    end
  end

`ifdef STC_NCO_DITHER_EN
  logic [15:0] lfsr_r;
  logic [31:0] dithered_s;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Dither LFSR steps with every accumulator update.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= 16'hACE1;
    end else if (valid1_r) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Dither replaces rounding; the accumulator itself is untouched.
  always_comb begin
    dithered_s   = phase_acc_r + {12'd0, lfsr_r, 4'b0000};
    phase_word_s = dithered_s[31:20];
  end
`else
  // Round-half-up to 12 bits, wrapping mod 4096.
  always_comb begin
    phase_word_s = phase_acc_r[31:20] + {11'd0, phase_acc_r[19]};
  end
`endif

  // Two-stage datapath: sum, accumulate, then registered phase word and strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r       <= 32'd0;
      valid1_r    <= 1'b0;
      phase_acc_r <= 32'd0;
      valid2_r    <= 1'b0;
      ncoPhase    <= 12'd0;
      ncoPhaseEn  <= 1'b0;
    end else begin
      valid1_r <= carrierFreqEn;
      if (carrierFreqEn) begin
        sum_r <= carrierFreqOffset + carrierLeadFreq + sweepOffset;
      end
      valid2_r <= valid1_r;
      if (valid1_r) begin
        phase_acc_r <= phase_acc_r + sum_r;
      end
      ncoPhaseEn <= valid2_r;
      if (valid2_r) begin
        ncoPhase <= phase_word_s;
      end
    end
  end

endmodule
